// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and
// load/muldiv writeback, with a scoreboard of registers that have writes in flight.
module rf_write_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_reg,
    input  logic [31:0]      req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_reg,
    input  logic [31:0]      req1_data,
    input  logic             rsv_en,
    input  logic [4:0]       rsv_reg,
    input  logic [4:0]       q_reg1,
    input  logic [4:0]       q_reg2,
    output logic             q_busy1,
    output logic             q_busy2,
    output logic [4:0]       writeReg,
    output logic [31:0]      writeData,
    output logic             writeEn,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Handshake: a write transfers on the edge where valid and ready are both
    // high; ready never rises without its valid, and at most one ready is high.
    logic        last_grant;
    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        accept;
    logic [4:0]  acc_reg;
    logic [31:0] acc_data;

    assign req0_ready = req0_valid && (!req1_valid || last_grant);
    assign req1_ready = req1_valid && (!req0_valid || !last_grant);
    assign accept     = req0_ready || req1_ready;
    assign acc_reg    = req0_ready ? req0_reg  : req1_reg;
    assign acc_data   = req0_ready ? req0_data : req1_data;

    // Reserve is applied after the clear so a newly issued producer keeps the bit.
    always_comb begin
        busy_next = busy;
        if (accept) begin
            busy_next[acc_reg] = 1'b0;
        end
        if (rsv_en && (rsv_reg != 5'd0)) begin
            busy_next[rsv_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            busy         <= '0;
            writeEn      <= 1'b0;
            writeReg     <= 5'd0;
            writeData    <= 32'd0;
            conflict_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (accept) begin
                last_grant <= req1_ready;
                writeReg   <= acc_reg;
                writeData  <= acc_data;
                writeEn    <= (acc_reg != 5'd0);
            end else begin
                writeEn <= 1'b0;
            end
            if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

    // The output-register term covers the cycle before the register file holds the data.
    assign q_busy1 = busy[q_reg1] | (writeEn && (writeReg == q_reg1) && (q_reg1 != 5'd0));
    assign q_busy2 = busy[q_reg2] | (writeEn && (writeReg == q_reg2) && (q_reg2 != 5'd0));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a scoreboard of expected
// register-file writes checked whenever writeEn is observed.
module tb_rf_write_arbiter;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [4:0]       req0_reg, req1_reg;
    logic [31:0]      req0_data, req1_data;
    logic             rsv_en;
    logic [4:0]       rsv_reg, q_reg1, q_reg2;
    logic             q_busy1, q_busy2;
    logic [4:0]       writeReg;
    logic [31:0]      writeData;
    logic             writeEn;
    logic [CNT_W-1:0] conflict_cnt;

    logic [36:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        tb_lg;

    rf_write_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .rsv_en(rsv_en), .rsv_reg(rsv_reg), .q_reg1(q_reg1), .q_reg2(q_reg2),
        .q_busy1(q_busy1), .q_busy2(q_busy2),
        .writeReg(writeReg), .writeData(writeData), .writeEn(writeEn),
        .conflict_cnt(conflict_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard monitor: every observed write must match the oldest expected one
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (writeEn === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got write reg=%0d data=%h, none expected", writeReg, writeData);
                end else begin
                    e = exp_q.pop_front();
                    if ({writeReg, writeData} !== e) begin
                        n_fail++;
                        $display("FAIL sb_write: got reg=%0d data=%h want reg=%0d data=%h",
                                 writeReg, writeData, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tb_lg = 1'b1;
    endtask

    task automatic test_reset();
        q_reg1 = 5'd5; q_reg2 = 5'd7;
        rst = 1'b1;
        step();
        step();
        n_checks++; if (writeEn !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", writeEn); end
        n_checks++; if (writeReg !== 5'd0) begin n_fail++; $display("FAIL reset_reg: got %0d want 0", writeReg); end
        n_checks++; if (writeData !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", writeData); end
        n_checks++; if (conflict_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        n_checks++; if ({q_busy1, q_busy2} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b want 00", {q_busy1, q_busy2}); end
        rst = 1'b0;
        tb_lg = 1'b1;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        tb_lg = 1'b0;
        step();
        idle();
        n_checks++; if (writeEn !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", writeEn); end
        n_checks++; if (writeReg !== 5'd5) begin n_fail++; $display("FAIL single_reg: got %0d want 5", writeReg); end
        n_checks++; if (writeData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", writeData); end
        step();
        n_checks++; if (writeEn !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b want 0", writeEn); end
        n_checks++; if (writeReg !== 5'd5) begin n_fail++; $display("FAIL single_reg_hold: got %0d want 5", writeReg); end
    endtask

    task automatic test_contention();
        logic g;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_reg = 5'd3; req0_data = $urandom;
            req1_valid = 1'b1; req1_reg = 5'd7; req1_data = $urandom;
            #1;
            g = ~tb_lg;
            n_checks++;
            if ({req0_ready, req1_ready} !== {~g, g}) begin
                n_fail++;
                $display("FAIL contention_grant%0d: got %b want %b", i, {req0_ready, req1_ready}, {~g, g});
            end
            exp_q.push_back(g ? {req1_reg, req1_data} : {req0_reg, req0_data});
            tb_lg = g;
            step();
        end
        idle();
        n_checks++; if (conflict_cnt !== 4'd4) begin n_fail++; $display("FAIL contention_cnt: got %0d want 4", conflict_cnt); end
        n_checks++; if (writeReg !== 5'd7) begin n_fail++; $display("FAIL contention_last_reg: got %0d want 7", writeReg); end
        step();
    endtask

    task automatic test_reserve();
        q_reg1 = 5'd9;
        rsv_en = 1'b1; rsv_reg = 5'd9;
        #1;
        n_checks++; if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL rsv_pre: got %b want 0", q_busy1); end
        step();
        rsv_en = 1'b0;
        n_checks++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL rsv_after1: got %b want 1", q_busy1); end
        step();
        req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'hA5A50009;
        #1;
        n_checks++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL rsv_after2: got %b want 1", q_busy1); end
        n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL rsv_ready: got %b want 01", {req0_ready, req1_ready}); end
        exp_q.push_back({5'd9, 32'hA5A50009});
        tb_lg = 1'b1;
        step();
        idle();
        n_checks++; if ({writeEn, q_busy1} !== 2'b11) begin n_fail++; $display("FAIL rsv_we_cycle: got we,busy=%b want 11", {writeEn, q_busy1}); end
        step();
        n_checks++; if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL rsv_free: got %b want 0", q_busy1); end
    endtask

    task automatic test_zero();
        q_reg2 = 5'd0;
        req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'h1234;
        rsv_en = 1'b1; rsv_reg = 5'd0;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", req0_ready); end
        n_checks++; if (q_busy2 !== 1'b0) begin n_fail++; $display("FAIL zero_busy_pre: got %b want 0", q_busy2); end
        tb_lg = 1'b0;
        step();
        idle();
        n_checks++; if (writeEn !== 1'b0) begin n_fail++; $display("FAIL zero_we: got %b want 0", writeEn); end
        n_checks++; if ({writeReg, writeData} !== {5'd0, 32'h1234}) begin n_fail++; $display("FAIL zero_outreg: got %0d/%h want 0/1234", writeReg, writeData); end
        n_checks++; if (q_busy2 !== 1'b0) begin n_fail++; $display("FAIL zero_busy_post: got %b want 0", q_busy2); end
        step();
    endtask

    task automatic test_same_cycle();
        q_reg1 = 5'd4;
        rsv_en = 1'b1; rsv_reg = 5'd4;
        step();
        req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'h44440004;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready: got %b want 1", req0_ready); end
        exp_q.push_back({5'd4, 32'h44440004});
        tb_lg = 1'b0;
        step();
        idle();
        n_checks++; if ({writeEn, q_busy1} !== 2'b11) begin n_fail++; $display("FAIL same_we_cycle: got we,busy=%b want 11", {writeEn, q_busy1}); end
        step();
        n_checks++; if ({writeEn, q_busy1} !== 2'b01) begin n_fail++; $display("FAIL same_still_busy: got we,busy=%b want 01", {writeEn, q_busy1}); end
    endtask

    task automatic test_reset_midop();
        for (int i = 10; i < 13; i++) begin
            rsv_en = 1'b1; rsv_reg = 5'(i);
            step();
        end
        rsv_en = 1'b0;
        q_reg1 = 5'd10; q_reg2 = 5'd12;
        #1;
        n_checks++; if ({q_busy1, q_busy2} !== 2'b11) begin n_fail++; $display("FAIL midop_reserved: got %b want 11", {q_busy1, q_busy2}); end
        req0_valid = 1'b1; req0_reg = 5'd13; req0_data = 32'h13;
        req1_valid = 1'b1; req1_reg = 5'd14; req1_data = 32'h14;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        tb_lg = 1'b1;
        n_checks++; if (writeEn !== 1'b0) begin n_fail++; $display("FAIL midop_we: got %b want 0", writeEn); end
        n_checks++; if ({q_busy1, q_busy2} !== 2'b00) begin n_fail++; $display("FAIL midop_busy: got %b want 00", {q_busy1, q_busy2}); end
        n_checks++; if (conflict_cnt !== '0) begin n_fail++; $display("FAIL midop_cnt: got %0d want 0", conflict_cnt); end
        q_reg1 = 5'd11;
        #1;
        n_checks++; if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL midop_busy11: got %b want 0", q_busy1); end
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h30;
        req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h70;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL midop_tie: got %b want 10", {req0_ready, req1_ready}); end
        exp_q.push_back({5'd3, 32'h30});
        tb_lg = 1'b0;
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic v0, v1, e0, e1;
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            v0 = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            v1 = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            req0_valid = v0; req0_reg = 5'($urandom_range(0, 31)); req0_data = $urandom;
            req1_valid = v1; req1_reg = 5'($urandom_range(0, 31)); req1_data = $urandom;
            #1;
            e0 = v0 && (!v1 || tb_lg);
            e1 = v1 && (!v0 || !tb_lg);
            n_checks++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b want %b", i, {req0_ready, req1_ready}, {e0, e1});
            end
            if (e0 && req0_reg != 5'd0) exp_q.push_back({req0_reg, req0_data});
            if (e1 && req1_reg != 5'd0) exp_q.push_back({req1_reg, req1_data});
            if (e0) tb_lg = 1'b0;
            if (e1) tb_lg = 1'b1;
            step();
        end
        idle();
        n_checks++; if (conflict_cnt !== 4'hF) begin n_fail++; $display("FAIL b2b_saturate: got %0d want 15", conflict_cnt); end
        step();
        step();
    endtask

    initial begin
        rst = 1'b0; idle();
        req0_reg = '0; req0_data = '0; req1_reg = '0; req1_data = '0;
        rsv_reg = '0; q_reg1 = '0; q_reg2 = '0; tb_lg = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_reserve();
        test_zero();
        test_same_cycle();
        test_reset_midop();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending writes want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
